// File: rtl/rob_commit.sv
// Reorder buffer with in-order single-entry retire; returns old_prd to the free list.
// Optional flush-at-commit on mispredict is enabled by defining ROB_FLUSH_AT_COMMIT_EN.
module rob_commit #(
    parameter int DEPTH  = 16,
    parameter int TAG_W  = $clog2(DEPTH),
    parameter int PREG_W = 7,
    parameter int AREG_W = 5,
    parameter int PC_W   = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alloc_valid,
    output logic              alloc_ready,
    output logic [TAG_W-1:0]  alloc_tag,
    input  logic              alloc_has_rd,
    input  logic [AREG_W-1:0] alloc_rd,
    input  logic [PREG_W-1:0] alloc_prd,
    input  logic [PREG_W-1:0] alloc_old_prd,
    input  logic [PC_W-1:0]   alloc_pc,
    input  logic              cmpl_valid,
    input  logic [TAG_W-1:0]  cmpl_tag,
    output logic              retire_valid,
    output logic [TAG_W-1:0]  retire_tag,
    output logic [AREG_W-1:0] retire_rd,
    output logic [PREG_W-1:0] retire_prd,
    output logic [PC_W-1:0]   retire_pc,
    output logic              free_valid,
    output logic [PREG_W-1:0] free_preg,
    output logic [TAG_W:0]    count,
    output logic              empty
`ifdef ROB_FLUSH_AT_COMMIT_EN
    ,
    input  logic              cmpl_mispredict,
    input  logic [PC_W-1:0]   cmpl_target,
    output logic              flush_valid,
    output logic [PC_W-1:0]   flush_pc
`endif
);

    localparam logic [TAG_W:0] FULL = (TAG_W+1)'(DEPTH);

    logic [TAG_W-1:0]  head, tail;
    logic [DEPTH-1:0]  valid, done;
    logic [DEPTH-1:0]  valid_nxt, done_nxt;

    logic              has_rd_q  [DEPTH];
    logic [AREG_W-1:0] rd_q      [DEPTH];
    logic [PREG_W-1:0] prd_q     [DEPTH];
    logic [PREG_W-1:0] old_prd_q [DEPTH];
    logic [PC_W-1:0]   pc_q      [DEPTH];

    logic do_alloc, do_retire, flush, alloc_fire;
    logic [TAG_W:0] count_nxt;

`ifdef ROB_FLUSH_AT_COMMIT_EN
    logic              mis_q [DEPTH];
    logic [PC_W-1:0]   tgt_q [DEPTH];
`endif

    assign alloc_ready = (count != FULL);
    assign alloc_tag   = tail;
    assign empty       = (count == '0);

    always_comb begin
        do_alloc  = alloc_valid && alloc_ready;
        do_retire = valid[head] && done[head];
`ifdef ROB_FLUSH_AT_COMMIT_EN
        flush     = do_retire && mis_q[head];
`else
        flush     = 1'b0;
`endif
        alloc_fire = do_alloc && !flush;
    end

    // Order matters: retire clears override a same-edge completion, a flush
    // overrides everything, and an allocation overrides a completion to tail.
    always_comb begin
        valid_nxt = valid;
        done_nxt  = done;
        if (cmpl_valid && valid[cmpl_tag]) begin
            done_nxt[cmpl_tag] = 1'b1;
        end
        if (do_retire) begin
            valid_nxt[head] = 1'b0;
            done_nxt[head]  = 1'b0;
        end
        if (flush) begin
            valid_nxt = '0;
            done_nxt  = '0;
        end else if (alloc_fire) begin
            valid_nxt[tail] = 1'b1;
            done_nxt[tail]  = 1'b0;
        end
        count_nxt = count + (TAG_W+1)'(alloc_fire) - (TAG_W+1)'(do_retire);
        if (flush) begin
            count_nxt = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            valid        <= '0;
            done         <= '0;
            retire_valid <= 1'b0;
            retire_tag   <= '0;
            retire_rd    <= '0;
            retire_prd   <= '0;
            retire_pc    <= '0;
            free_valid   <= 1'b0;
            free_preg    <= '0;
        end else begin
            valid <= valid_nxt;
            done  <= done_nxt;
            count <= count_nxt;
            if (do_retire) begin
                head <= head + 1'b1;
            end
            if (flush) begin
                tail <= head + 1'b1;
            end else if (alloc_fire) begin
                tail <= tail + 1'b1;
            end
            retire_valid <= do_retire;
            free_valid   <= do_retire && has_rd_q[head] && (old_prd_q[head] != '0);
            if (do_retire) begin
                retire_tag <= head;
                retire_rd  <= rd_q[head];
                retire_prd <= prd_q[head];
                retire_pc  <= pc_q[head];
                free_preg  <= old_prd_q[head];
            end
        end
    end

    // Payload needs no reset: it is only read once valid/done gate it.
    always_ff @(posedge clk) begin
        if (alloc_fire) begin
            has_rd_q[tail]  <= alloc_has_rd;
            rd_q[tail]      <= alloc_rd;
            prd_q[tail]     <= alloc_prd;
            old_prd_q[tail] <= alloc_old_prd;
            pc_q[tail]      <= alloc_pc;
        end
`ifdef ROB_FLUSH_AT_COMMIT_EN
        if (cmpl_valid && valid[cmpl_tag]) begin
            mis_q[cmpl_tag] <= cmpl_mispredict;
            tgt_q[cmpl_tag] <= cmpl_target;
        end
`endif
    end

`ifdef ROB_FLUSH_AT_COMMIT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flush_valid <= 1'b0;
            flush_pc    <= '0;
        end else begin
            flush_valid <= flush;
            if (flush) begin
                flush_pc <= tgt_q[head];
            end
        end
    end
`endif

endmodule

// File: tb/tb_rob_commit.sv
// Randomised bench for rob_commit: queue-based reference model checked every cycle,
// plus directed sequences with literal expectations.
module tb_rob_commit;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       alloc_valid = 1'b0, alloc_ready, alloc_has_rd = 1'b0;
    logic [3:0] alloc_tag;
    logic [4:0] alloc_rd = '0;
    logic [6:0] alloc_prd = '0, alloc_old_prd = '0;
    logic [8:0] alloc_pc = '0;
    logic       cmpl_valid = 1'b0;
    logic [3:0] cmpl_tag = '0;
    logic       cmpl_mispredict = 1'b0;
    logic [8:0] cmpl_target = '0;
    logic       retire_valid, free_valid, empty;
    logic [3:0] retire_tag;
    logic [4:0] retire_rd;
    logic [6:0] retire_prd, free_preg;
    logic [8:0] retire_pc;
    logic [4:0] count;
    logic       flush_valid;
    logic [8:0] flush_pc;

    rob_commit #(.DEPTH(16), .TAG_W(4), .PREG_W(7), .AREG_W(5), .PC_W(9)) dut (
        .clk(clk), .rst(rst),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
        .alloc_has_rd(alloc_has_rd), .alloc_rd(alloc_rd), .alloc_prd(alloc_prd),
        .alloc_old_prd(alloc_old_prd), .alloc_pc(alloc_pc),
        .cmpl_valid(cmpl_valid), .cmpl_tag(cmpl_tag),
        .retire_valid(retire_valid), .retire_tag(retire_tag), .retire_rd(retire_rd),
        .retire_prd(retire_prd), .retire_pc(retire_pc),
        .free_valid(free_valid), .free_preg(free_preg),
        .count(count), .empty(empty)
`ifdef ROB_FLUSH_AT_COMMIT_EN
        ,
        .cmpl_mispredict(cmpl_mispredict), .cmpl_target(cmpl_target),
        .flush_valid(flush_valid), .flush_pc(flush_pc)
`endif
    );

`ifndef ROB_FLUSH_AT_COMMIT_EN
    assign flush_valid = 1'b0;
    assign flush_pc    = '0;
`endif

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference model: program-order queue of in-flight instructions
    typedef struct {
        logic [3:0] tag;
        logic       has_rd;
        logic [4:0] rd;
        logic [6:0] prd;
        logic [6:0] old_prd;
        logic [8:0] pc;
        bit         done;
        bit         mis;
        logic [8:0] tgt;
    } ent_t;

    typedef struct {
        logic [3:0] tag;
        logic       fv;
        logic [6:0] fp;
        logic       fl;
        logic [8:0] flpc;
    } ret_t;

    ent_t q[$];
    ret_t rlog[$];
    logic [3:0] m_tail;
    logic       e_rv, e_fv, e_flv;
    logic [3:0] e_rtag;
    logic [4:0] e_rrd;
    logic [6:0] e_rprd, e_fp;
    logic [8:0] e_rpc, e_flpc;

    always @(posedge clk or negedge rst) begin
        ent_t r, n;
        bit   can_alloc, fl;
        if (!rst) begin
            q.delete();
            m_tail = 0;
            e_rv = 0; e_fv = 0; e_flv = 0; e_rtag = 0; e_rrd = 0;
            e_rprd = 0; e_fp = 0; e_rpc = 0; e_flpc = 0;
        end else begin
            can_alloc = (q.size() < DEPTH);
            fl = 0;
            e_rv = 0; e_fv = 0; e_flv = 0;
            if (q.size() > 0 && q[0].done) begin
                r = q.pop_front();
                e_rv = 1; e_rtag = r.tag; e_rrd = r.rd; e_rprd = r.prd; e_rpc = r.pc;
                e_fv = r.has_rd && (r.old_prd != 0);
                e_fp = r.old_prd;
`ifdef ROB_FLUSH_AT_COMMIT_EN
                if (r.mis) begin
                    fl = 1; e_flv = 1; e_flpc = r.tgt;
                end
`endif
            end
            if (cmpl_valid) begin
                foreach (q[i]) begin
                    if (q[i].tag == cmpl_tag) begin
                        q[i].done = 1; q[i].mis = cmpl_mispredict; q[i].tgt = cmpl_target;
                    end
                end
            end
            if (fl) begin
                q.delete();
                m_tail = r.tag + 4'd1;
            end else if (alloc_valid && can_alloc) begin
                n.tag = m_tail; n.has_rd = alloc_has_rd; n.rd = alloc_rd; n.prd = alloc_prd;
                n.old_prd = alloc_old_prd; n.pc = alloc_pc; n.done = 0; n.mis = 0; n.tgt = 0;
                q.push_back(n);
                m_tail = m_tail + 4'd1;
            end
        end
    end

    always @(posedge clk) begin
        ret_t l;
        #1;
        chk("retire_valid", retire_valid, e_rv);
        chk("retire_tag", retire_tag, e_rtag);
        chk("retire_rd", retire_rd, e_rrd);
        chk("retire_prd", retire_prd, e_rprd);
        chk("retire_pc", retire_pc, e_rpc);
        chk("free_valid", free_valid, e_fv);
        if (e_fv) chk("free_preg", free_preg, e_fp);
        chk("count", count, q.size());
        chk("empty", empty, q.size() == 0);
        chk("alloc_ready", alloc_ready, q.size() != DEPTH);
        chk("alloc_tag", alloc_tag, m_tail);
        chk("flush_valid", flush_valid, e_flv);
        if (e_flv) chk("flush_pc", flush_pc, e_flpc);
        if (retire_valid) begin
            l.tag = retire_tag; l.fv = free_valid; l.fp = free_preg;
            l.fl = flush_valid; l.flpc = flush_pc;
            rlog.push_back(l);
        end
    end

    task automatic cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic reset_pulse();
        rst = 1'b0;
        alloc_valid = 1'b0;
        cmpl_valid = 1'b0;
        cycle();
        rst = 1'b1;
    endtask

    task automatic alloc_one(input logic [4:0] rd, input logic [6:0] prd,
                             input logic [6:0] old_prd, input logic [8:0] pc);
        alloc_valid = 1'b1; alloc_has_rd = (rd != 0); alloc_rd = rd;
        alloc_prd = prd; alloc_old_prd = old_prd; alloc_pc = pc;
        cycle();
        alloc_valid = 1'b0;
    endtask

    task automatic complete(input logic [3:0] tag, input logic mis, input logic [8:0] tgt);
        cmpl_valid = 1'b1; cmpl_tag = tag; cmpl_mispredict = mis; cmpl_target = tgt;
        cycle();
        cmpl_valid = 1'b0; cmpl_mispredict = 1'b0;
    endtask

    initial begin
        int base;
        logic [4:0] rds  [5] = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd0};
        logic [6:0] prds [5] = '{7'd32, 7'd33, 7'd34, 7'd35, 7'd0};
        logic [6:0] olds [5] = '{7'd1, 7'd2, 7'd3, 7'd4, 7'd0};

        repeat (3) cycle();
        rst = 1'b1;
        chk("rst_alloc_tag", alloc_tag, 0);
        chk("rst_alloc_ready", alloc_ready, 1);
        chk("rst_empty", empty, 1);

        // Five allocations, then out-of-order completion
        for (int i = 0; i < 5; i++) begin
            chk("dir_alloc_tag", alloc_tag, i);
            alloc_one(rds[i], prds[i], olds[i], 9'(i * 4));
        end
        chk("dir_count5", count, 5);
        chk("dir_no_retire", retire_valid, 0);
        base = rlog.size();
        complete(4'd2, 1'b0, '0);
        complete(4'd0, 1'b0, '0);
        complete(4'd1, 1'b0, '0);
        repeat (3) cycle();
        chk("dir_nret3", rlog.size() - base, 3);
        if (rlog.size() >= base + 3) begin
            for (int i = 0; i < 3; i++) begin
                chk("dir_ret_tag", rlog[base+i].tag, i);
                chk("dir_free_preg", rlog[base+i].fp, i + 1);
            end
        end
        base = rlog.size();
        complete(4'd4, 1'b0, '0);
        complete(4'd3, 1'b0, '0);
        repeat (3) cycle();
        chk("dir_nret2", rlog.size() - base, 2);
        if (rlog.size() >= base + 2) begin
            chk("dir_tag3", rlog[base].tag, 3);
            chk("dir_tag3_fv", rlog[base].fv, 1);
            chk("dir_tag3_fp", rlog[base].fp, 4);
            chk("dir_tag4", rlog[base+1].tag, 4);
            chk("dir_tag4_fv", rlog[base+1].fv, 0);
        end
        chk("dir_empty", empty, 1);

        // Fill to full, overflow attempt, drain one, wrap
        reset_pulse();
        for (int i = 0; i < 16; i++) alloc_one(5'(i + 1), 7'(40 + i), 7'(i + 1), 9'(i));
        chk("full_count", count, 16);
        chk("full_ready", alloc_ready, 0);
        alloc_one(5'd9, 7'd99, 7'd9, 9'h1ff);
        chk("full_ignored", count, 16);
        complete(4'd0, 1'b0, '0);
        cycle();
        chk("drain_ready", alloc_ready, 1);
        chk("wrap_tag", alloc_tag, 0);
        chk("drain_count", count, 15);

        // Async reset mid-operation
        reset_pulse();
        for (int i = 0; i < 6; i++) alloc_one(5'(i + 1), 7'(50 + i), 7'(i + 1), 9'(i));
        complete(4'd1, 1'b0, '0);
        complete(4'd0, 1'b0, '0);
        rst = 1'b0;
        #1;
        chk("arst_count", count, 0);
        chk("arst_empty", empty, 1);
        chk("arst_tag", alloc_tag, 0);
        chk("arst_rv", retire_valid, 0);
        chk("arst_fv", free_valid, 0);
        base = rlog.size();
        cycle();
        rst = 1'b1;
        repeat (4) cycle();
        chk("arst_no_retire", rlog.size(), base);

`ifdef ROB_FLUSH_AT_COMMIT_EN
        reset_pulse();
        for (int i = 0; i < 4; i++) alloc_one(5'(i + 1), 7'(60 + i), 7'(i + 1), 9'(i));
        base = rlog.size();
        complete(4'd1, 1'b1, 9'h040);
        complete(4'd0, 1'b0, '0);
        repeat (3) cycle();
        chk("fl_nret", rlog.size() - base, 2);
        if (rlog.size() >= base + 2) begin
            chk("fl_tag0", rlog[base].tag, 0);
            chk("fl_tag0_nofl", rlog[base].fl, 0);
            chk("fl_tag1", rlog[base+1].tag, 1);
            chk("fl_flush", rlog[base+1].fl, 1);
            chk("fl_pc", rlog[base+1].flpc, 9'h040);
        end
        chk("fl_count", count, 0);
        chk("fl_alloc_tag", alloc_tag, 2);
`endif

        // Randomised traffic
        reset_pulse();
        for (int c = 0; c < 3000; c++) begin
            alloc_valid   = ($urandom_range(3) != 0);
            alloc_rd      = 5'($urandom);
            alloc_has_rd  = (alloc_rd != 0) && ($urandom_range(7) != 0);
            alloc_prd     = 7'($urandom);
            alloc_old_prd = ($urandom_range(5) == 0) ? 7'd0 : 7'($urandom);
            alloc_pc      = 9'($urandom);
            cmpl_valid    = ($urandom_range(9) < 6);
            if (q.size() > 0 && $urandom_range(7) != 0)
                cmpl_tag = q[$urandom_range(q.size() - 1)].tag;
            else
                cmpl_tag = 4'($urandom);
`ifdef ROB_FLUSH_AT_COMMIT_EN
            cmpl_mispredict = ($urandom_range(15) == 0);
            cmpl_target     = 9'($urandom);
`endif
            cycle();
        end
        alloc_valid = 1'b0;
        cmpl_valid  = 1'b0;
        repeat (3) cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
